// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI word transmitter.
// No logic; no latency or backpressure of its own.
package spi_tx_pkg;

   localparam int SPI_WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_tx_clkgen.sv
// SCK divider: HALF_DIV clk cycles per sck half-period while en is high, sck parked low otherwise.
// rise/fall strobe the cycle before sck toggles; no backpressure.
module spi_tx_clkgen #(
   parameter int HALF_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          sck_q;
   logic          tick;

   assign tick = en && (cnt == CW'(HALF_DIV - 1));
   assign rise = tick && !sck_q;
   assign fall = tick && sck_q;
   assign sck  = sck_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         sck_q <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         sck_q <= 1'b0;
      end else if (tick) begin
         cnt   <= '0;
         sck_q <= ~sck_q;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_transmitter.sv
// Mode-0 SPI master serializer: one DATA_WIDTH word per scs-low frame, MSB first.
// First sck rise 1+CS_SETUP+HALF_DIV cycles after accept; tx_ready_o only in IDLE.
module spi_transmitter
   import spi_tx_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_WORD_W,
   parameter int HALF_DIV   = 2,
   parameter int CS_SETUP   = 1,
   parameter int CS_HOLD    = 1,
   parameter int IDLE_GAP   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  scs_o,
   output logic                  sck_o,
   output logic                  sdo_o
);

   if (DATA_WIDTH < 2) begin : g_bad_width
      $error("spi_transmitter: DATA_WIDTH must be >= 2");
   end
   if (HALF_DIV < 1) begin : g_bad_div
      $error("spi_transmitter: HALF_DIV must be >= 1");
   end
   if (CS_SETUP < 1 || CS_HOLD < 1 || IDLE_GAP < 1) begin : g_bad_phase
      $error("spi_transmitter: CS_SETUP, CS_HOLD and IDLE_GAP must be >= 1");
   end

   localparam int PH_MAX = max3(CS_SETUP, CS_HOLD, IDLE_GAP);
   localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int BW     = $clog2(DATA_WIDTH);

   state_t                state, state_nxt;
   logic [PW-1:0]         ph_cnt;
   logic [PW-1:0]         ph_lim;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-2:0] shreg;
   logic                  last_hi;
   logic                  accept, ph_done, last_fall;
   logic                  sck_en, sck_rise, sck_fall;

   assign accept    = tx_valid_i && tx_ready_o;
   assign sck_en    = (state == SHIFT);
   assign ph_done   = (ph_cnt == ph_lim);
   assign last_fall = sck_fall && last_hi;

   spi_tx_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (sck_en),
      .sck  (sck_o),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   always_comb begin
      ph_lim = '0;
      case (state)
         SETUP:   ph_lim = PW'(CS_SETUP - 1);
         HOLD:    ph_lim = PW'(CS_HOLD - 1);
         GAP:     ph_lim = PW'(IDLE_GAP - 1);
         default: ph_lim = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = SETUP;
         SETUP:   if (ph_done)   state_nxt = SHIFT;
         SHIFT:   if (last_fall) state_nxt = HOLD;
         HOLD:    if (ph_done)   state_nxt = GAP;
         GAP:     if (ph_done)   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Outputs are registered from the next state so scs/ready/busy change in step with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scs_o      <= 1'b1;
         sdo_o      <= 1'b0;
         tx_ready_o <= 1'b1;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         ph_cnt     <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         last_hi    <= 1'b0;
      end else begin
         scs_o      <= !(state_nxt inside {SETUP, SHIFT, HOLD});
         tx_ready_o <= (state_nxt == IDLE);
         busy_o     <= (state_nxt != IDLE);
         done_o     <= (state == HOLD) && (state_nxt == GAP);

         if (state_nxt != state || state == IDLE || state == SHIFT) ph_cnt <= '0;
         else                                                      ph_cnt <= ph_cnt + PW'(1);

         if (accept) begin
            sdo_o   <= tx_data_i[DATA_WIDTH-1];
            shreg   <= tx_data_i[DATA_WIDTH-2:0];
            bit_cnt <= '0;
            last_hi <= 1'b0;
         end else if (sck_rise && bit_cnt == BW'(DATA_WIDTH - 1)) begin
            last_hi <= 1'b1;
         end else if (sck_fall && !last_hi) begin
            // next bit goes out on the falling edge so it is stable across the following rise
            sdo_o   <= shreg[DATA_WIDTH-2];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BW'(1);
         end else if (state == HOLD && state_nxt == GAP) begin
            sdo_o   <= 1'b0;
            shreg   <= '0;
            last_hi <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_transmitter.sv
// Directed bench: default-parameter DUT plus a HALF_DIV=1/CS_SETUP=3 DUT, each observed by a
// Mode-0 receiver model that records per-frame word, rise count, scs-low time, latency and gap.
module tb_spi_transmitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data  [2];
   logic        valid [2];
   logic        ready [2];
   logic        busy  [2];
   logic        done  [2];
   logic        scs   [2];
   logic        sck   [2];
   logic        sdo   [2];

   always #5 clk = ~clk;

   spi_transmitter dut0 (
      .clk(clk), .rst_n(rst_n), .tx_data_i(data[0]), .tx_valid_i(valid[0]),
      .tx_ready_o(ready[0]), .busy_o(busy[0]), .done_o(done[0]),
      .scs_o(scs[0]), .sck_o(sck[0]), .sdo_o(sdo[0])
   );

   spi_transmitter #(.HALF_DIV(1), .CS_SETUP(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_data_i(data[1]), .tx_valid_i(valid[1]),
      .tx_ready_o(ready[1]), .busy_o(busy[1]), .done_o(done[1]),
      .scs_o(scs[1]), .sck_o(sck[1]), .sdo_o(sdo[1])
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- receiver model / protocol monitor ----------------
   logic [31:0] rx_sh    [2];
   int          rise_cnt [2];
   int          low_cnt  [2];
   int          high_cnt [2];
   int          lat_cnt  [2];
   bit          lat_act  [2];
   int          cur_lat  [2];
   int          cur_gap  [2];
   logic        p_sck [2], p_sdo [2], p_scs [2];
   int          viol [2], done_miss [2], done_bad [2];
   int          nfr [2];
   logic [31:0] fr_word  [2][8];
   int          fr_rises [2][8];
   int          fr_low   [2][8];
   int          fr_lat   [2][8];
   int          fr_gap   [2][8];

   initial begin
      for (int d = 0; d < 2; d++) begin
         nfr[d] = 0; viol[d] = 0; done_miss[d] = 0; done_bad[d] = 0;
         rx_sh[d] = '0; rise_cnt[d] = 0; low_cnt[d] = 0; high_cnt[d] = 0;
         lat_cnt[d] = 0; lat_act[d] = 1'b0; cur_lat[d] = -1; cur_gap[d] = -1;
         p_sck[d] = 1'b0; p_sdo[d] = 1'b0; p_scs[d] = 1'b1;
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic is_rise;
         is_rise = sck[d] && !p_sck[d];
         if (!rst_n) begin
            rx_sh[d] = '0; rise_cnt[d] = 0; low_cnt[d] = 0; high_cnt[d] = 0;
            lat_act[d] = 1'b0;
         end else begin
            if (valid[d] && ready[d]) begin
               lat_cnt[d] = 0; lat_act[d] = 1'b1;
            end else if (lat_act[d]) begin
               lat_cnt[d]++;
            end
            if (is_rise && sdo[d] !== p_sdo[d]) viol[d]++;
            if (is_rise && lat_act[d]) begin
               cur_lat[d] = lat_cnt[d]; lat_act[d] = 1'b0;
            end
            if (is_rise && !scs[d]) begin
               rx_sh[d] = {rx_sh[d][30:0], sdo[d]};
               rise_cnt[d]++;
            end
            if (!scs[d] && p_scs[d]) cur_gap[d] = high_cnt[d];
            if (!scs[d]) low_cnt[d]++;
            else         high_cnt[d]++;
            if (scs[d] && !p_scs[d]) begin
               if (!done[d]) done_miss[d]++;
               if (nfr[d] < 8) begin
                  fr_word[d][nfr[d]]  = rx_sh[d];
                  fr_rises[d][nfr[d]] = rise_cnt[d];
                  fr_low[d][nfr[d]]   = low_cnt[d];
                  fr_lat[d][nfr[d]]   = cur_lat[d];
                  fr_gap[d][nfr[d]]   = cur_gap[d];
               end
               nfr[d]++;
               rx_sh[d] = '0; rise_cnt[d] = 0; low_cnt[d] = 0; high_cnt[d] = 1;
            end else if (done[d]) begin
               done_bad[d]++;
            end
         end
         p_sck[d] = sck[d]; p_sdo[d] = sdo[d]; p_scs[d] = scs[d];
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_word(input int d, input logic [31:0] w, output bit ok);
      data[d]  = w;
      valid[d] = 1'b1;
      ok       = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         if (ready[d]) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end
      end
   endtask

   // data is scrambled every cycle while waiting: the DUT must ignore it once busy
   task automatic wait_frames(input int d, input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         if (nfr[d] >= n) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
            data[d] = $urandom;
         end
      end
   endtask

   typedef struct {
      int          dut;
      logic [31:0] word;
      bit          chain;     // keep tx_valid_i high and present the next vector's word
      int          exp_low;
      int          exp_lat;
      int          exp_gap;   // 0: gap not checked
   } vec_t;

   vec_t vec [7];
   int   fvec [2][8];
   int   exp_n [2];
   int   chk_n [2];

   initial begin
      bit ok;
      int base;

      vec[0] = '{0, 32'hA5C3_0F81, 1'b0, 130, 4, 0};
      vec[1] = '{0, 32'h0000_0001, 1'b1, 130, 4, 0};
      vec[2] = '{0, 32'hFFFF_FFFF, 1'b0, 130, 4, 3};
      vec[3] = '{0, 32'h8000_0000, 1'b0, 130, 4, 0};
      vec[4] = '{1, 32'hA5C3_0F81, 1'b0, 68, 5, 0};
      vec[5] = '{1, 32'h0000_0001, 1'b1, 68, 5, 0};
      vec[6] = '{1, 32'h7E5A_3CC3, 1'b0, 68, 5, 3};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         valid[d] = 1'b0; data[d] = '0; exp_n[d] = 0; chk_n[d] = 0;
      end

      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst scs d%0d", d),   scs[d],   1'b1);
         chk($sformatf("rst sck d%0d", d),   sck[d],   1'b0);
         chk($sformatf("rst sdo d%0d", d),   sdo[d],   1'b0);
         chk($sformatf("rst ready d%0d", d), ready[d], 1'b1);
         chk($sformatf("rst busy d%0d", d),  busy[d],  1'b0);
         chk($sformatf("rst done d%0d", d),  done[d],  1'b0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle scs",   scs[0],   1'b1);
      chk("idle sck",   sck[0],   1'b0);
      chk("idle ready", ready[0], 1'b1);
      chk("idle busy",  busy[0],  1'b0);
      chk("idle frames", nfr[0],  0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         int d;
         d = vec[i].dut;
         send_word(d, vec[i].word, ok);
         chk($sformatf("accept v%0d", i), ok, 1'b1);
         fvec[d][exp_n[d]] = i;
         exp_n[d]++;
         if (vec[i].chain) begin
            data[d] = vec[i+1].word;
         end else begin
            valid[d] = 1'b0;
            wait_frames(d, exp_n[d], ok);
            chk($sformatf("frame end v%0d", i), ok, 1'b1);
            for (int k = chk_n[d]; k < exp_n[d]; k++) begin
               int v;
               v = fvec[d][k];
               chk($sformatf("word v%0d", v),  fr_word[d][k],  vec[v].word);
               chk($sformatf("rises v%0d", v), fr_rises[d][k], 32);
               chk($sformatf("scs low v%0d", v), fr_low[d][k], vec[v].exp_low);
               chk($sformatf("latency v%0d", v), fr_lat[d][k], vec[v].exp_lat);
               if (vec[v].exp_gap != 0)
                  chk($sformatf("gap v%0d", v), fr_gap[d][k], vec[v].exp_gap);
            end
            chk_n[d] = exp_n[d];
            repeat (4) @(posedge clk);
            #1;
         end
      end

      // reset in the middle of a frame
      base = nfr[0];
      send_word(0, 32'hDEAD_BEEF, ok);
      chk("accept mid-rst word", ok, 1'b1);
      valid[0] = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
         @(negedge clk);
         if (rise_cnt[0] == 10) ok = 1'b1;
      end
      chk("reach 10 rises", ok, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async rst scs", scs[0], 1'b1);
      chk("async rst sck", sck[0], 1'b0);
      chk("async rst done", done[0], 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no frame after rst", nfr[0], base);
      chk("ready after rst", ready[0], 1'b1);
      @(posedge clk); #1;
      send_word(0, 32'h5A5A_C3C3, ok);
      chk("accept post-rst", ok, 1'b1);
      valid[0] = 1'b0;
      wait_frames(0, base + 1, ok);
      chk("post-rst frame end", ok, 1'b1);
      chk("post-rst word",  fr_word[0][base],  32'h5A5A_C3C3);
      chk("post-rst rises", fr_rises[0][base], 32);
      chk("post-rst scs low", fr_low[0][base], 130);
      repeat (5) @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("sdo moved on rise d%0d", d), viol[d], 0);
         chk($sformatf("done missing d%0d", d), done_miss[d], 0);
         chk($sformatf("stray done d%0d", d), done_bad[d], 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
